// File: rtl/fetch_stage.sv
// MIPS32 instruction-fetch stage: program counter, instruction-memory address
// and the IF/ID pipeline register, with wait-state, stall and redirect handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  opcode
);

  // Memory handshake: imem_addr is a registered request that is always
  // outstanding; a beat completes on any rising edge where imem_ready=1 and
  // the stage is neither stalled nor redirecting. Otherwise the word is dropped.

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_pc;

  assign pc_plus4    = pc_q + 32'd4;
  assign jump_target = {pc4_q[31:28], instr_q[25:0], 2'b00};
  assign branch_pc   = {branch_target[31:2], 2'b00};

  // Redirect priority: a taken branch overrides a stall because the stalled
  // ID instruction is on the wrong path; jump only acts on a real instruction.
  always_comb begin
    pc_d    = pc_q;
    instr_d = 32'h0;
    pc4_d   = 32'h0;
    valid_d = 1'b0;
    if (branch_taken) begin
      pc_d = branch_pc;
    end else if (stall) begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end else if (jump && valid_q) begin
      pc_d = jump_target;
    end else if (imem_ready) begin
      pc_d    = pc_plus4;
      instr_d = imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign opcode      = instr_q[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays instruction memory and the
// control unit, and checks PC and IF/ID after every clock edge.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;

  int checks;
  int errors;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .opcode       (opcode)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] exp_pc,
                           input logic [31:0] exp_instr, input logic [31:0] exp_pc4,
                           input logic exp_valid);
    logic [5:0] exp_op;
    exp_op = exp_instr[31:26];
    chk32({tag, ".pc"},        pc,                  exp_pc);
    chk32({tag, ".imem_addr"}, imem_addr,           exp_pc);
    chk32({tag, ".instr"},     if_id_instr,         exp_instr);
    chk32({tag, ".pc4"},       if_id_pc4,           exp_pc4);
    chk32({tag, ".valid"},     {31'h0, if_id_valid}, {31'h0, exp_valid});
    chk32({tag, ".opcode"},    {26'h0, opcode},      {26'h0, exp_op});
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    imem_rdata    = 32'h0;
    imem_ready    = 1'b1;

    // reset state, then sequential fetch with zero-wait memory
    #3;
    chk_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    #4 rst = 1'b0;
    imem_rdata = 32'h2008_0005;
    step();
    chk_state("seq0", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
    chk32("seq0.op_addi", {26'h0, opcode}, 32'h0000_0008);
    imem_rdata = 32'h200A_0003;
    step();
    chk_state("seq1", 32'h8, 32'h200A_0003, 32'h8, 1'b1);
    imem_rdata = 32'h012A_4020;
    step();
    chk_state("seq2", 32'hC, 32'h012A_4020, 32'hC, 1'b1);
    chk32("seq2.op_rtype", {26'h0, opcode}, 32'h0);
    imem_rdata = 32'h0000_0000;
    step();
    chk_state("seq3", 32'h10, 32'h0, 32'h10, 1'b1);

    // three wait states at pc=0x10
    imem_ready = 1'b0;
    imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state("wait", 32'h10, 32'h0, 32'h0, 1'b0);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'h8C09_0004;
    step();
    chk_state("wait_done", 32'h14, 32'h8C09_0004, 32'h14, 1'b1);

    // stall for two cycles with a ready word that must not be consumed
    stall      = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    chk_state("stall0", 32'h14, 32'h8C09_0004, 32'h14, 1'b1);
    step();
    chk_state("stall1", 32'h14, 32'h8C09_0004, 32'h14, 1'b1);
    stall      = 1'b0;
    imem_rdata = 32'h1111_1111;
    step();
    chk_state("refetch", 32'h18, 32'h1111_1111, 32'h18, 1'b1);

    // taken branch in the same cycle as a stall; low target bits dropped
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0043;
    step();
    chk_state("br_stall", 32'h40, 32'h0, 32'h0, 1'b0);
    stall        = 1'b0;
    branch_taken = 1'b0;
    imem_rdata   = 32'h2222_2222;
    step();
    chk_state("br_tgt", 32'h44, 32'h2222_2222, 32'h44, 1'b1);

    // reset mid-cycle, then build IF/ID = j 0x100 with pc4=8
    rst = 1'b1;
    #1;
    chk_state("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    rst        = 1'b0;
    imem_rdata = 32'h0000_0000;
    step();
    chk_state("j_pre0", 32'h4, 32'h0, 32'h4, 1'b1);
    imem_rdata = 32'h0800_0040;
    step();
    chk_state("j_pre1", 32'h8, 32'h0800_0040, 32'h8, 1'b1);
    chk32("j_pre1.op_j", {26'h0, opcode}, 32'h0000_0002);

    // jump: word at 0x8 squashed, one bubble; jump held high over the
    // bubble must be ignored
    jump       = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    step();
    chk_state("j_bubble", 32'h100, 32'h0, 32'h0, 1'b0);
    imem_rdata = 32'h2402_0001;
    step();
    chk_state("j_target", 32'h104, 32'h2402_0001, 32'h104, 1'b1);
    jump = 1'b0;

    // branch during a wait state to the top word, then wrap to 0
    imem_ready    = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    step();
    chk_state("br_wait", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    imem_ready   = 1'b1;
    imem_rdata   = 32'h3C01_0001;
    step();
    chk_state("wrap", 32'h0, 32'h3C01_0001, 32'h0, 1'b1);
    imem_rdata = 32'h2008_0005;
    step();
    chk_state("post_wrap", 32'h4, 32'h2008_0005, 32'h4, 1'b1);

    // asynchronous reset away from any clock edge
    #2 rst = 1'b1;
    #1;
    chk_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    chk_state("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0);
    rst        = 1'b0;
    imem_rdata = 32'h200A_0003;
    step();
    chk_state("rst_fetch", 32'h4, 32'h200A_0003, 32'h4, 1'b1);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
